memory_write_controller: RTL and testbench
==========================================

Name: memory_write_controller

Overview:
- Write-side counterpart of the matrix memory read controller.
- Accepts one 16-bit value or a packed 48-bit triple from the pipeline MEM stage and drives the matrix memory write port.
- Writes one value, or three consecutive values along a row (horizontal) or column (vertical), then acknowledges with HANDSHAKE.
- Addresses are {row[31:16], col[15:0]}; Ctrl encoding matches the read controller.

Parameters:
WORD_W, 16, width of one memory word.
N_WORDS, 3, words per multiple transfer; WRITE width = WORD_W*N_WORDS.
HALF_W, 16, width of the row and col address fields.

Ports:
CLK  in  1  system clock.
RESET  in  1  asynchronous, active-high reset.
CLK_MEM  in  1  memory tick qualifier; state advances only on CLK edges where CLK_MEM=1.
ENABLE  in  1  request; held high until HANDSHAKE is seen.
Ctrl  in  2  [0]=0 single write, Ctrl[1] ignored; [0]=1 multiple write, [1]=0 horizontal (col+1), [1]=1 vertical (row+1).
ADDRESS  in  32  base address {row, col}.
WRITE  in  48  data; word k = WRITE[16k+15:16k]; single mode uses WRITE[15:0] only.
AddressMem  out  32  memory address.
WriteMem  out  16  memory write data.
WE  out  1  memory write enable.
HANDSHAKE  out  1  transfer complete.

Behaviour:
- Reset (async): state IDLE; AddressMem=0, WriteMem=0, WE=0, HANDSHAKE=0; latch registers cleared.
- States: IDLE, WR0, WR1, WR2, DONE.
- Outputs are decoded from the registered state and latch registers only. No combinational path from ADDRESS, WRITE, or Ctrl to the outputs.
- ENABLE=0 on any CLK edge, regardless of CLK_MEM: state goes to IDLE next cycle. This aborts a burst mid-way; words already written stay written, and no further WE is issued.
- IDLE: outputs 0. On a tick with ENABLE=1, latch ADDRESS, Ctrl, and WRITE, then go to WR0.
- WR0: AddressMem = base, WriteMem = word0, WE=1.
  - Tick: go to WR1 if Ctrl[0]=1, otherwise DONE.
- WR1: AddressMem = base+1 on the selected field, WriteMem = word1, WE=1. Tick: go to WR2.
- WR2: AddressMem = base+2 on the selected field, WriteMem = word2, WE=1. Tick: go to DONE.
- WE is high for exactly one tick period per word. When CLK_MEM=1 every cycle, that is exactly one CLK cycle per word.
- DONE: WE=0, AddressMem=0, HANDSHAKE=1.
  - Stays in DONE while ENABLE=1, so only one write per request.
  - When ENABLE drops, go to IDLE and HANDSHAKE falls to 0 the next cycle.
- Latency with CLK_MEM always 1, counting the request edge as edge 0:
  - Single: WE during cycle 1, HANDSHAKE from cycle 2.
  - Multiple: WE during cycles 1-3, HANDSHAKE from cycle 4.
- Address arithmetic:
  - Only the selected 16-bit field increments, modulo 2^16.
  - 0xFFFF+1 wraps to 0x0000 with no carry into the other field.
- ADDRESS, WRITE, and Ctrl changes after the latch edge are ignored until the next IDLE→WR0 transition.
- CLK_MEM=0 freezes the state and all outputs; WE stays asserted if the block is in a WR state.

Decomposition:
- Package mem_ctrl_pkg holds:
  - Ctrl bit indices and encodings: CTRL_MULTI=0, CTRL_VERT=1.
  - The state enum.
  - WORD_W, N_WORDS, HALF_W.
  - A function that picks word k from the 48-bit bus.
  - The read controller adopts the same package.
- Sub-module memory_addr_gen (combinational) computes {row, col+k} or {row+k, col} for k=0..2 with the 16-bit wrap rule. It is shared with the read controller.

Test Plan:
- Single write: ADDRESS=0x0002_0005, Ctrl=2'b00, WRITE=0x…_1234 -> one WE cycle with AddressMem=0x00020005 and WriteMem=0x1234; HANDSHAKE=1 two cycles after request; no second WE while ENABLE stays high.
- Horizontal burst: ADDRESS=0x0001_0003, Ctrl=2'b01, WRITE=0xCCCC_BBBB_AAAA -> writes (0x00010003,0xAAAA), (0x00010004,0xBBBB), (0x00010005,0xCCCC) on consecutive cycles, then HANDSHAKE.
- Vertical burst with wrap: ADDRESS=0xFFFE_0007, Ctrl=2'b11 -> AddressMem = 0xFFFE0007, 0xFFFF0007, 0x00000007; col unchanged.
- CLK_MEM stall: CLK_MEM=1 every 4th cycle during a horizontal burst -> each word held with WE=1 for 4 CLK cycles; address/data sequence as in scenario 2.
- ENABLE dropped in WR1: WE=0 and state IDLE next cycle; word2 never written; HANDSHAKE stays 0.
- RESET asserted mid-burst (not clock aligned): WE, HANDSHAKE, AddressMem, and WriteMem go to 0 immediately; after release with ENABLE=1, a fresh transfer starts from WR0.

Source files
------------

// File: rtl/memory_write_controller_pkg.sv
// Shared definitions for the matrix memory read/write controllers:
// word geometry, Ctrl bit meaning, the transfer state enum and a word picker.
package mem_ctrl_pkg;

  localparam int WORD_W  = 16;
  localparam int N_WORDS = 3;
  localparam int HALF_W  = 16;

  // Ctrl bit positions.
  localparam int CTRL_MULTI = 0;  // 0: single word, 1: three-word burst
  localparam int CTRL_VERT  = 1;  // burst direction: 0 col+1, 1 row+1

  // Full Ctrl encodings.
  localparam logic [1:0] CTRL_SINGLE = 2'b00;
  localparam logic [1:0] CTRL_HORIZ  = 2'b01;
  localparam logic [1:0] CTRL_VERTIC = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR0,
    WR1,
    WR2,
    DONE
  } state_e;

  // Word k of a packed multi-word bus; word 0 sits in the low bits.
  function automatic logic [WORD_W-1:0] get_word(
    input logic [WORD_W*N_WORDS-1:0] data,
    input logic [1:0]                k
  );
    return data[k*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/memory_write_controller_if.sv
// Request/response and memory-port signals between the MEM stage and the
// write controller. The MEM stage is the master, the controller the slave.
interface memory_write_controller_if;
  import mem_ctrl_pkg::*;

  logic                        ENABLE;
  logic [1:0]                  Ctrl;
  logic [2*HALF_W-1:0]         ADDRESS;
  logic [WORD_W*N_WORDS-1:0]   WRITE;
  logic [2*HALF_W-1:0]         AddressMem;
  logic [WORD_W-1:0]           WriteMem;
  logic                        WE;
  logic                        HANDSHAKE;

  modport master (
    output ENABLE, Ctrl, ADDRESS, WRITE,
    input  AddressMem, WriteMem, WE, HANDSHAKE
  );

  modport slave (
    input  ENABLE, Ctrl, ADDRESS, WRITE,
    output AddressMem, WriteMem, WE, HANDSHAKE
  );

endinterface

// File: rtl/memory_write_controller_addr_gen.sv
// Address of word k of a transfer: adds k to either the row or the column
// field. Each field wraps on its own, so there is never a carry between them.
module memory_addr_gen
  import mem_ctrl_pkg::*;
(
  input  logic [2*HALF_W-1:0] base,
  input  logic [1:0]          k,
  input  logic                vert,
  output logic [2*HALF_W-1:0] addr
);

  logic [HALF_W-1:0] row;
  logic [HALF_W-1:0] col;
  logic [HALF_W-1:0] step;

  // Split, bump the selected field modulo 2^HALF_W, reassemble.
  always_comb begin
    row  = base[2*HALF_W-1:HALF_W];
    col  = base[HALF_W-1:0];
    step = HALF_W'(k);
    if (vert) addr = {row + step, col};
    else      addr = {row, col + step};
  end

endmodule

// File: rtl/memory_write_controller.sv
// Matrix memory write controller: latches a request, writes one word or a
// three-word row/column burst (advancing only on CLK_MEM ticks), then holds
// HANDSHAKE until the request is withdrawn. Outputs depend only on the
// registered state and latched request, never on the live request inputs.
module memory_write_controller
  import mem_ctrl_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      CLK_MEM,
  memory_write_controller_if.slave  bus
);

  state_e                      state_q;
  state_e                      state_d;
  logic [2*HALF_W-1:0]         base_q;
  logic [1:0]                  ctrl_q;
  logic [WORD_W*N_WORDS-1:0]   data_q;
  logic [1:0]                  word_idx;
  logic [2*HALF_W-1:0]         gen_addr;
  logic                        latch_en;

  assign latch_en = (state_q == IDLE) && CLK_MEM && bus.ENABLE;

  // State register and request latch.
  // NOTE: the latch registers are reset too, so the outputs never show stale
  // data from a transfer interrupted by RESET.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      base_q  <= '0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q <= state_d;
      if (latch_en) begin
        base_q <= bus.ADDRESS;
        ctrl_q <= bus.Ctrl;
        data_q <= bus.WRITE;
      end
    end
  end

  // Next state: a withdrawn request aborts at once; otherwise advance on ticks.
  always_comb begin
    // NOTE: default first so no path through this block infers a latch.
    state_d = state_q;
    if (!bus.ENABLE) begin
      state_d = IDLE;
    end else if (CLK_MEM) begin
      unique case (state_q)
        IDLE:    state_d = WR0;
        WR0:     state_d = ctrl_q[CTRL_MULTI] ? WR1 : DONE;
        WR1:     state_d = WR2;
        WR2:     state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  memory_addr_gen u_addr_gen (
    .base (base_q),
    .k    (word_idx),
    .vert (ctrl_q[CTRL_VERT]),
    .addr (gen_addr)
  );

  // Output decode from the registered state and latched request.
  always_comb begin
    word_idx       = 2'd0;
    bus.AddressMem = '0;
    bus.WriteMem   = '0;
    bus.WE         = 1'b0;
    bus.HANDSHAKE  = 1'b0;
    unique case (state_q)
      WR0, WR1, WR2: begin
        word_idx       = (state_q == WR0) ? 2'd0 : (state_q == WR1) ? 2'd1 : 2'd2;
        bus.AddressMem = gen_addr;
        bus.WriteMem   = get_word(data_q, word_idx);
        bus.WE         = 1'b1;
      end
      DONE:    bus.HANDSHAKE = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memory_write_controller.sv
// Bench for memory_write_controller: directed table of transfers, random
// transfers against an arithmetic address/data model, and hand-written
// abort and asynchronous-reset sequences.
module tb_memory_write_controller;
  import mem_ctrl_pkg::*;

  logic CLK;
  logic RESET;
  logic CLK_MEM;
  int   n_tests;
  int   n_fail;

  memory_write_controller_if bus ();

  memory_write_controller dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .CLK_MEM (CLK_MEM),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [1:0]  ctrl;
    logic [47:0] wdata;
    bit          stall;
    logic [95:0] exp_a;  // word k address at [32k +: 32]
    logic [47:0] exp_d;  // word k data at [16k +: 16]
  } vec_t;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: word k of a transfer lands at the base with only the chosen
  // 16-bit field advanced by k, modulo 65536.
  function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [1:0] c, input int k);
    int row;
    int col;
    row = int'(a[31:16]);
    col = int'(a[15:0]);
    if (c[0]) begin
      if (c[1]) row = (row + k) % 65536;
      else      col = (col + k) % 65536;
    end
    return {16'(row), 16'(col)};
  endfunction

  // One full request: raise ENABLE, scramble the inputs after the latch edge,
  // record every WE sample and the HANDSHAKE cycle, then withdraw.
  task automatic run_xfer(input string name, input logic [31:0] a, input logic [1:0] c,
                          input logic [47:0] w, input bit stall,
                          input logic [95:0] ea, input logic [47:0] ed);
    int n, hold, cyc, hs_cyc, idx, k;
    n = c[0] ? 3 : 1;
    hold = stall ? 4 : 1;
    @(negedge CLK);
    CLK_MEM = 1'b1;
    bus.ADDRESS = a;
    bus.Ctrl = c;
    bus.WRITE = w;
    bus.ENABLE = 1'b1;
    cyc = 0;
    hs_cyc = -1;
    idx = 0;
    while (hs_cyc < 0 && cyc < 100) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) begin
        bus.ADDRESS = $urandom;
        bus.WRITE = 48'({$urandom, $urandom});
        bus.Ctrl = ~c;
      end
      if (bus.WE) begin
        if (idx < n * hold) begin
          k = idx / hold;
          check({name, " addr"}, 48'(bus.AddressMem), 48'(ea[k*32 +: 32]));
          check({name, " data"}, 48'(bus.WriteMem), 48'(ed[k*16 +: 16]));
        end
        idx++;
      end
      if (bus.HANDSHAKE) hs_cyc = cyc;
      if (stall) CLK_MEM = ((cyc % 4) == 0);
    end
    check({name, " we samples"}, 48'(idx), 48'(n * hold));
    check({name, " handshake cycle"}, 48'(hs_cyc), 48'(n * hold + 1));
    CLK_MEM = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check({name, " no rewrite"}, 48'(bus.WE), 48'(0));
      check({name, " hs held"}, 48'(bus.HANDSHAKE), 48'(1));
    end
    bus.ENABLE = 1'b0;
    @(negedge CLK);
    check({name, " hs drop"}, 48'(bus.HANDSHAKE), 48'(0));
    check({name, " addr idle"}, 48'(bus.AddressMem), 48'(0));
  endtask

  vec_t vecs [6];

  initial begin
    logic [31:0] ra;
    logic [1:0]  rc;
    logic [47:0] rw;
    logic [95:0] rea;
    bit          rs;

    n_tests = 0;
    n_fail = 0;

    vecs[0] = '{"single", 32'h0002_0005, 2'b00, 48'hDEAD_BEEF_1234, 1'b0,
                {64'h0, 32'h0002_0005}, 48'h0000_0000_1234};
    vecs[1] = '{"horiz", 32'h0001_0003, 2'b01, 48'hCCCC_BBBB_AAAA, 1'b0,
                {32'h0001_0005, 32'h0001_0004, 32'h0001_0003}, 48'hCCCC_BBBB_AAAA};
    vecs[2] = '{"vert wrap", 32'hFFFE_0007, 2'b11, 48'h3333_2222_1111, 1'b0,
                {32'h0000_0007, 32'hFFFF_0007, 32'hFFFE_0007}, 48'h3333_2222_1111};
    vecs[3] = '{"horiz stall", 32'h0001_0003, 2'b01, 48'hCCCC_BBBB_AAAA, 1'b1,
                {32'h0001_0005, 32'h0001_0004, 32'h0001_0003}, 48'hCCCC_BBBB_AAAA};
    vecs[4] = '{"col wrap", 32'h0001_FFFF, 2'b01, 48'h0F0F_E0E0_5A5A, 1'b0,
                {32'h0001_0001, 32'h0001_0000, 32'h0001_FFFF}, 48'h0F0F_E0E0_5A5A};
    vecs[5] = '{"single ctrl1 ignored", 32'h1234_5678, 2'b10, 48'h1111_2222_9ABC, 1'b0,
                {64'h0, 32'h1234_5678}, 48'h0000_0000_9ABC};

    // Reset state.
    RESET = 1'b1;
    CLK_MEM = 1'b1;
    bus.ENABLE = 1'b0;
    bus.Ctrl = 2'b00;
    bus.ADDRESS = '0;
    bus.WRITE = '0;
    #1;
    check("reset WE", 48'(bus.WE), 48'(0));
    check("reset HANDSHAKE", 48'(bus.HANDSHAKE), 48'(0));
    check("reset AddressMem", 48'(bus.AddressMem), 48'(0));
    check("reset WriteMem", 48'(bus.WriteMem), 48'(0));
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("idle WE", 48'(bus.WE), 48'(0));

    // Directed table.
    for (int i = 0; i < 6; i++)
      run_xfer(vecs[i].name, vecs[i].addr, vecs[i].ctrl, vecs[i].wdata,
               vecs[i].stall, vecs[i].exp_a, vecs[i].exp_d);

    // Random transfers, biased toward field wrap.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 2) == 0) ra[31:16] = 16'hFFFE + 16'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) ra[15:0]  = 16'hFFFE + 16'($urandom_range(0, 1));
      rc = 2'($urandom_range(0, 3));
      rw = 48'({$urandom, $urandom});
      rs = ($urandom_range(0, 3) == 0);
      rea = {model_addr(ra, rc, 2), model_addr(ra, rc, 1), model_addr(ra, rc, 0)};
      run_xfer("random", ra, rc, rw, rs, rea, rw);
    end

    // Abort in WR1, with CLK_MEM low on the abort edge.
    @(negedge CLK);
    bus.ADDRESS = 32'h0020_0030;
    bus.Ctrl = 2'b01;
    bus.WRITE = 48'h7777_6666_5555;
    bus.ENABLE = 1'b1;
    @(negedge CLK);
    check("abort WR0 addr", 48'(bus.AddressMem), 48'h0000_0020_0030);
    @(negedge CLK);
    check("abort WR1 WE", 48'(bus.WE), 48'(1));
    check("abort WR1 addr", 48'(bus.AddressMem), 48'h0000_0020_0031);
    bus.ENABLE = 1'b0;
    CLK_MEM = 1'b0;
    @(negedge CLK);
    CLK_MEM = 1'b1;
    check("abort WE off", 48'(bus.WE), 48'(0));
    check("abort HS off", 48'(bus.HANDSHAKE), 48'(0));
    repeat (3) begin
      @(negedge CLK);
      check("abort stays idle WE", 48'(bus.WE), 48'(0));
      check("abort stays idle HS", 48'(bus.HANDSHAKE), 48'(0));
    end

    // Asynchronous reset mid-burst, then a fresh single transfer.
    @(negedge CLK);
    bus.ADDRESS = 32'h0005_0006;
    bus.Ctrl = 2'b01;
    bus.WRITE = 48'hABCD_4321_8765;
    bus.ENABLE = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("pre-reset WE", 48'(bus.WE), 48'(1));
    #2;
    RESET = 1'b1;
    #1;
    check("async reset WE", 48'(bus.WE), 48'(0));
    check("async reset HS", 48'(bus.HANDSHAKE), 48'(0));
    check("async reset addr", 48'(bus.AddressMem), 48'(0));
    check("async reset data", 48'(bus.WriteMem), 48'(0));
    @(negedge CLK);
    RESET = 1'b0;
    bus.ADDRESS = 32'h0007_0008;
    bus.Ctrl = 2'b00;
    bus.WRITE = 48'h0000_0000_C0DE;
    @(negedge CLK);
    check("restart WE", 48'(bus.WE), 48'(1));
    check("restart addr", 48'(bus.AddressMem), 48'h0000_0007_0008);
    check("restart data", 48'(bus.WriteMem), 48'h0000_0000_C0DE);
    @(negedge CLK);
    check("restart HS", 48'(bus.HANDSHAKE), 48'(1));
    bus.ENABLE = 1'b0;
    @(negedge CLK);
    check("restart HS drop", 48'(bus.HANDSHAKE), 48'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
